time_keeper24: RTL and testbench
================================

TIME_KEEPER24 -- requirements
Module: time_keeper24

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 50000000, giving the number of clk cycles per second; legal range is 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port run, input, 1 bit: 1 = timekeeping advances, 0 = frozen.
REQ-005 The block SHALL have port load, input, 1 bit: single-cycle request to adopt a newly set time (driven by the setter's propagate pulse).
REQ-006 The block SHALL have port load_hours, input, 5 bits: hour value to load, legal range 0..23.
REQ-007 The block SHALL have port load_minutes, input, 6 bits: minute value to load, legal range 0..59.
REQ-008 The block SHALL have port hours, output reg, 5 bits: current hour, range 0..23.
REQ-009 The block SHALL have port minutes, output reg, 6 bits: current minute, range 0..59.
REQ-010 The block SHALL have port seconds, output reg, 6 bits: current second, range 0..59.
REQ-011 The block SHALL have port sec_pulse, output reg, 1 bit: one-cycle strobe issued each time seconds advances.
REQ-012 The block SHALL have port day_pulse, output reg, 1 bit: one-cycle strobe on the 23:59:59 -> 00:00:00 rollover.
REQ-013 The block SHALL have port time_valid, output reg, 1 bit: 1 once a legal load has been accepted since reset.
REQ-014 The block SHALL have port load_err, output reg, 1 bit: one-cycle strobe flagging a rejected load.

Function
REQ-015 Prescaler: an internal counter SHALL count 0..TICKS_PER_SEC-1 while run=1 and hold while run=0.
REQ-016 Tick: when the prescaler is at TICKS_PER_SEC-1 and run=1, the prescaler SHALL return to 0, seconds SHALL advance on that edge, and sec_pulse SHALL be 1 for exactly that following cycle.
REQ-017 Seconds: a value of 59 SHALL wrap to 0 and carry into minutes on the same edge; otherwise seconds SHALL increment by 1.
REQ-018 Minutes: minutes SHALL advance only on a seconds carry; 59 SHALL wrap to 0 and carry into hours on the same edge.
REQ-019 Hours: hours SHALL advance only on a minutes carry; 23 SHALL wrap to 0.
REQ-020 Rollover: day_pulse SHALL assert for one cycle coincident with the sec_pulse whose edge moves 23:59:59 to 00:00:00.
REQ-021 Legal load: load=1 with load_hours<=23 and load_minutes<=59 SHALL, on that edge, set hours and minutes to the load values, seconds to 0, the prescaler to 0, and time_valid to 1.
REQ-022 Load priority: a legal load SHALL take priority over a coincident tick; no increment and no sec_pulse or day_pulse SHALL occur in that cycle.
REQ-023 Illegal load: load=1 with load_hours>23 or load_minutes>59 SHALL leave all time state and time_valid unchanged, pulse load_err for one cycle, and still allow a coincident tick to proceed normally.
REQ-024 Load acceptance SHALL be independent of run; a legal load while run=0 updates the time, which then stays frozen.
REQ-025 Counting SHALL proceed regardless of time_valid; time_valid is informational only.
REQ-026 All outputs SHALL be registered, and updated values SHALL appear after the clk edge that causes them.
REQ-027 The load inputs SHALL be held stable only during the load cycle; no handshake or acknowledge SHALL exist.

Reset
REQ-028 reset=1 SHALL immediately clear hours, minutes, seconds and the prescaler to 0, and clear sec_pulse, day_pulse, time_valid and load_err to 0, independent of clk.
REQ-029 Reset asserted mid-count or during load SHALL abort the operation with no partial update; the first tick after reset release SHALL occur TICKS_PER_SEC cycles after the first edge with run=1.
REQ-030 reset SHALL dominate load and run.

Verification (TICKS_PER_SEC=4 for sim)
REQ-031 Reset then run=1 for 8 cycles -> sec_pulse at cycles 4 and 8, seconds=2, time_valid=0.
REQ-032 Load 23:59, then tick 60 seconds -> day_pulse with the 60th sec_pulse, and time reads 00:00:00.
REQ-033 Load 10:30 coincident with the prescaler at terminal count -> 10:30:00, no sec_pulse, and the next sec_pulse 4 cycles later.
REQ-034 Load 24:00, then 05:60 -> load_err pulses twice, time unchanged, time_valid unchanged.
REQ-035 Load 12:00 while run=0 for 20 cycles -> time stays 12:00:00 with no sec_pulse; after run=1 the first sec_pulse comes 4 cycles later.
REQ-036 Reset asserted between clk edges at 07:15:42 -> all outputs read 0 before the next edge.

Source files
------------

// File: rtl/time_keeper24.sv
// rtl/time_keeper24.sv - 24-hour hh:mm:ss timekeeper with prescaler, load and rollover strobes
module time_keeper24 #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       time_valid,
  output logic       load_err
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          load_ok;
  logic          load_bad;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hour_wrap;

  // Decode the one-second tick and classify any load request
  always_comb begin
    tick      = run && (presc == TERM);
    load_ok   = load && (load_hours <= 5'd23) && (load_minutes <= 6'd59);
    load_bad  = load && !((load_hours <= 5'd23) && (load_minutes <= 6'd59));
    sec_wrap  = (seconds == 6'd59);
    min_wrap  = (minutes == 6'd59);
    hour_wrap = (hours == 5'd23);
  end

  // Prescaler, time-of-day cascade, strobes; a legal load overrides a coincident tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      hours      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      sec_pulse  <= 1'b0;
      day_pulse  <= 1'b0;
      time_valid <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= load_bad;
      if (load_ok) begin
        presc      <= '0;
        hours      <= load_hours;
        minutes    <= load_minutes;
        seconds    <= '0;
        time_valid <= 1'b1;
      end else begin
        if (run) begin
          presc <= tick ? '0 : presc + 1'b1;
        end
        if (tick) begin
          sec_pulse <= 1'b1;
          day_pulse <= sec_wrap && min_wrap && hour_wrap;
          if (sec_wrap) begin
            seconds <= '0;
            if (min_wrap) begin
              minutes <= '0;
              hours   <= hour_wrap ? 5'd0 : hours + 5'd1;
            end else begin
              minutes <= minutes + 6'd1;
            end
          end else begin
            seconds <= seconds + 6'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_time_keeper24.sv
// tb/tb_time_keeper24.sv - directed self-checking bench for time_keeper24
module tb_time_keeper24;

  logic       clk;
  logic       reset;
  logic       run;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_pulse;
  logic       day_pulse;
  logic       time_valid;
  logic       load_err;

  int checks;
  int failures;
  int n_sec;
  int n_day;
  int day_at;

  time_keeper24 #(.TICKS_PER_SEC(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .load         (load),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .sec_pulse    (sec_pulse),
    .day_pulse    (day_pulse),
    .time_valid   (time_valid),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hours"}, 32'(hours), 32'(h));
    check({tag, ".minutes"}, 32'(minutes), 32'(m));
    check({tag, ".seconds"}, 32'(seconds), 32'(s));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    run = 1'b0;
    load = 1'b0;
    load_hours = '0;
    load_minutes = '0;

    // reset state
    #3;
    check_time("reset", 0, 0, 0);
    check("reset.sec_pulse", 32'(sec_pulse), 0);
    check("reset.day_pulse", 32'(day_pulse), 0);
    check("reset.time_valid", 32'(time_valid), 0);
    check("reset.load_err", 32'(load_err), 0);
    #9;
    reset = 1'b0;
    run = 1'b1;

    // run 8 cycles: strobes at cycles 4 and 8
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("run8.sec_pulse[%0d]", k), 32'(sec_pulse), (k == 4 || k == 8) ? 1 : 0);
    end
    check("run8.seconds", 32'(seconds), 2);
    check("run8.time_valid", 32'(time_valid), 0);

    // load 23:59 then 60 seconds to midnight
    load = 1'b1; load_hours = 5'd23; load_minutes = 6'd59;
    step();
    load = 1'b0;
    check_time("ld2359", 23, 59, 0);
    check("ld2359.time_valid", 32'(time_valid), 1);
    check("ld2359.sec_pulse", 32'(sec_pulse), 0);
    n_sec = 0; n_day = 0; day_at = -1;
    for (int k = 0; k < 240; k++) begin
      step();
      if (sec_pulse) n_sec++;
      if (day_pulse) begin
        n_day++;
        day_at = sec_pulse ? n_sec : -2;
      end
    end
    check("roll.sec_count", 32'(n_sec), 60);
    check("roll.day_count", 32'(n_day), 1);
    check("roll.day_at", 32'(day_at), 60);
    check_time("roll", 0, 0, 0);

    // legal load coincident with terminal count
    step(); step(); step();
    load = 1'b1; load_hours = 5'd10; load_minutes = 6'd30;
    step();
    load = 1'b0;
    check_time("ldterm", 10, 30, 0);
    check("ldterm.sec_pulse", 32'(sec_pulse), 0);
    check("ldterm.day_pulse", 32'(day_pulse), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("ldterm.next_pulse[%0d]", k), 32'(sec_pulse), (k == 4) ? 1 : 0);
    end
    check_time("ldterm.after", 10, 30, 1);

    // illegal loads: 24:00 then 05:60
    load = 1'b1; load_hours = 5'd24; load_minutes = 6'd0;
    step();
    check("bad24.load_err", 32'(load_err), 1);
    check_time("bad24", 10, 30, 1);
    check("bad24.time_valid", 32'(time_valid), 1);
    load_hours = 5'd5; load_minutes = 6'd60;
    step();
    load = 1'b0;
    check("bad60.load_err", 32'(load_err), 1);
    check_time("bad60", 10, 30, 1);
    check("bad60.time_valid", 32'(time_valid), 1);
    step();
    check("bad.err_clear", 32'(load_err), 0);
    // illegal load coincident with a tick lets the tick through
    load = 1'b1; load_hours = 5'd31; load_minutes = 6'd0;
    step();
    load = 1'b0;
    check("badtick.load_err", 32'(load_err), 1);
    check("badtick.sec_pulse", 32'(sec_pulse), 1);
    check_time("badtick", 10, 30, 2);

    // legal load while frozen
    run = 1'b0;
    load = 1'b1; load_hours = 5'd12; load_minutes = 6'd0;
    step();
    load = 1'b0;
    check_time("frz.load", 12, 0, 0);
    n_sec = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (sec_pulse) n_sec++;
    end
    check("frz.sec_count", 32'(n_sec), 0);
    check_time("frz.hold", 12, 0, 0);
    run = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("frz.resume[%0d]", k), 32'(sec_pulse), (k == 4) ? 1 : 0);
    end
    check_time("frz.after", 12, 0, 1);

    // reach 07:15:42 then assert reset between edges
    load = 1'b1; load_hours = 5'd7; load_minutes = 6'd15;
    step();
    load = 1'b0;
    for (int k = 0; k < 168; k++) step();
    check_time("pre_rst", 7, 15, 42);
    check("pre_rst.sec_pulse", 32'(sec_pulse), 1);
    #2;
    reset = 1'b1;
    #1;
    check_time("async_rst", 0, 0, 0);
    check("async_rst.sec_pulse", 32'(sec_pulse), 0);
    check("async_rst.day_pulse", 32'(day_pulse), 0);
    check("async_rst.time_valid", 32'(time_valid), 0);
    check("async_rst.load_err", 32'(load_err), 0);
    // reset dominates load and run
    load = 1'b1; load_hours = 5'd3; load_minutes = 6'd3;
    step();
    load = 1'b0;
    check_time("rst_dom", 0, 0, 0);
    check("rst_dom.time_valid", 32'(time_valid), 0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("post_rst.pulse[%0d]", k), 32'(sec_pulse), (k == 4) ? 1 : 0);
    end
    check_time("post_rst", 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
